// File: rtl/chess_move_streamer.sv
// chess_move_streamer: move FIFO + two-byte serialiser paced by a host read strobe.
// Define CHESS_MOVE_COUNT_EN to append a popped-move count byte after the 0xFF terminator.
module chess_move_streamer #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       flush,
  input  logic       mv_valid,
  output logic       mv_ready,
  input  logic [5:0] mv_from,
  input  logic [5:0] mv_to,
  input  logic [1:0] mv_flags,
  input  logic       gen_done,
  input  logic       rd_pin,
  output logic [7:0] out_byte,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_HI,
    S_LO,
    S_DONE,
    S_DONE_CNT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [13:0]            mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   done_pending;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rd_prev;
  logic                   rd_evt;
  logic                   push;
  logic                   pop;
  logic                   done_clr;
  logic [13:0]            head;

  assign mv_ready = ena & (count != CW'(DEPTH));
  assign push     = mv_valid & mv_ready & ~flush;
  assign rd_evt   = sync_q[SYNC_STAGES-1] & ~rd_prev & ena;
  assign pop      = (state == S_LO) & rd_evt & ~flush;
  assign head     = mem[rd_ptr];
  assign busy     = (count != '0) | done_pending;

`ifdef CHESS_MOVE_COUNT_EN
  logic [7:0] mv_cnt;

  assign done_clr = (state == S_DONE_CNT) & rd_evt;

  // popped-move counter, saturating, cleared once the count byte is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_cnt <= '0;
    end else if (flush || done_clr) begin
      mv_cnt <= '0;
    end else if (pop && mv_cnt != 8'hFF) begin
      mv_cnt <= mv_cnt + 8'd1;
    end
  end
`else
  assign done_clr = (state == S_DONE) & rd_evt;
`endif

  // move storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {mv_flags, mv_to, mv_from};
    end
  end

  // FIFO pointers, occupancy and the end-of-list flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      done_pending <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      done_pending <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (gen_done) begin
        done_pending <= 1'b1;
      end else if (done_clr) begin
        done_pending <= 1'b0;
      end
    end
  end

  // read-strobe synchroniser and edge register; flush leaves these alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      rd_prev <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rd_pin};
      rd_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode; flush overrides everything
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_EMPTY: begin
        if (count != '0) begin
          state_nxt = S_HI;
        end else if (done_pending) begin
          state_nxt = S_DONE;
        end
      end
      S_HI: begin
        if (rd_evt) begin
          state_nxt = S_LO;
        end
      end
      S_LO: begin
        if (rd_evt) begin
          if (count > CW'(1)) begin
            state_nxt = S_HI;
          end else if (done_pending) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_EMPTY;
          end
        end
      end
      S_DONE: begin
        if (rd_evt) begin
`ifdef CHESS_MOVE_COUNT_EN
          state_nxt = S_DONE_CNT;
`else
          state_nxt = S_EMPTY;
`endif
        end
      end
`ifdef CHESS_MOVE_COUNT_EN
      S_DONE_CNT: begin
        if (rd_evt) begin
          state_nxt = S_EMPTY;
        end
      end
`endif
      default: state_nxt = S_EMPTY;
    endcase
    if (flush) begin
      state_nxt = S_EMPTY;
    end
  end

  // byte presented to the host, decoded from state and FIFO head
  always_comb begin
    out_byte = 8'h00;
    unique case (state)
      S_HI:       out_byte = {2'b10, head[5:0]};
      S_LO:       out_byte = {head[13:12], head[11:6]};
      S_DONE:     out_byte = 8'hFF;
`ifdef CHESS_MOVE_COUNT_EN
      S_DONE_CNT: out_byte = mv_cnt;
`endif
      default:    out_byte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_chess_move_streamer.sv
// tb_chess_move_streamer: scoreboard bench for the move streamer.
// Honours CHESS_MOVE_COUNT_EN to expect the trailing count byte.
module tb_chess_move_streamer;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
`ifdef CHESS_MOVE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       flush = 1'b0;
  logic       mv_valid = 1'b0;
  logic       mv_ready;
  logic [5:0] mv_from = '0;
  logic [5:0] mv_to = '0;
  logic [1:0] mv_flags = '0;
  logic       gen_done = 1'b0;
  logic       rd_pin = 1'b0;
  logic [7:0] out_byte;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  chess_move_streamer #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush),
    .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_from(mv_from), .mv_to(mv_to), .mv_flags(mv_flags),
    .gen_done(gen_done), .rd_pin(rd_pin),
    .out_byte(out_byte), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every byte the host sampled is matched in order
  initial begin : monitor
    logic [7:0] b;
    forever begin
      wait (obs_q.size() != 0);
      b = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL byte: got %02h want nothing", b);
      end else begin
        chk("byte", b, exp_q.pop_front());
      end
    end
  end

  // expected host view of one move
  task automatic expect_move(input logic [5:0] f, input logic [5:0] t,
                             input logic [1:0] fl);
    exp_q.push_back({2'b10, f});
    exp_q.push_back({fl, t});
  endtask

  task automatic push_mv(input logic [5:0] f, input logic [5:0] t,
                         input logic [1:0] fl);
    @(negedge clk);
    mv_valid = 1'b1;
    mv_from = f;
    mv_to = t;
    mv_flags = fl;
    expect_move(f, t, fl);
    @(negedge clk);
    mv_valid = 1'b0;
  endtask

  task automatic pulse_done(input int n);
    @(negedge clk);
    gen_done = 1'b1;
    exp_q.push_back(8'hFF);
    if (CNT_EN) exp_q.push_back(8'(n));
    @(negedge clk);
    gen_done = 1'b0;
  endtask

  task automatic strobe();
    rd_pin = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    @(negedge clk);
    rd_pin = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    @(negedge clk);
  endtask

  // host read: byte-0 phase polls past 0x00, byte-1 phase samples directly
  task automatic read_byte(input bit poll);
    int t;
    t = 0;
    @(negedge clk);
    if (poll) begin
      while (out_byte == 8'h00 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) begin
        checks++;
        errors++;
        $display("FAIL poll_timeout: got %02h want nonzero", out_byte);
      end
    end
    obs_q.push_back(out_byte);
    strobe();
  endtask

  task automatic read_end();
    read_byte(1'b1);
    if (CNT_EN) read_byte(1'b0);
  endtask

  task automatic flush_t();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle_chk(input string name);
    repeat (2) @(negedge clk);
    chk({name, "_out"}, out_byte, 8'h00);
    chk({name, "_busy"}, {7'b0, busy}, 8'h00);
  endtask

  task automatic drv(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      mv_valid = 1'b1;
      mv_from = 6'($urandom);
      mv_to = 6'($urandom);
      mv_flags = 2'($urandom);
      t = 0;
      while (!mv_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!mv_ready) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: got ready=0 want 1");
      end else begin
        expect_move(mv_from, mv_to, mv_flags);
      end
      @(negedge clk);
      mv_valid = 1'b0;
    end
    pulse_done(n);
  endtask

  task automatic rdr(input int n);
    for (int k = 0; k < 2 * n; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      read_byte(k % 2 == 0);
    end
    read_end();
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: got hang want finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin : main
    logic [5:0] f;
    logic [5:0] t;
    logic [1:0] fl;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_out", out_byte, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_ready", {7'b0, mv_ready}, 8'h01);
    rst_n = 1'b1;

    @(negedge clk);
    strobe();
    chk("empty_rd", out_byte, 8'h00);

    ena = 1'b0;
    @(negedge clk);
    chk("ena_ready", {7'b0, mv_ready}, 8'h00);
    mv_valid = 1'b1;
    @(negedge clk);
    mv_valid = 1'b0;
    strobe();
    chk("ena_busy", {7'b0, busy}, 8'h00);
    chk("ena_out", out_byte, 8'h00);
    ena = 1'b1;

    flush_t();
    push_mv(6'd12, 6'd28, 2'b00);
    pulse_done(1);
    read_byte(1'b1);
    read_byte(1'b0);
    read_end();
    idle_chk("single");

    flush_t();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      f = 6'($urandom);
      t = 6'($urandom);
      fl = 2'($urandom);
      mv_valid = 1'b1;
      mv_from = f;
      mv_to = t;
      mv_flags = fl;
      chk("fill_ready", {7'b0, mv_ready}, {7'b0, 1'(i < DEPTH)});
      if (i < DEPTH) expect_move(f, t, fl);
    end
    @(negedge clk);
    mv_valid = 1'b0;
    chk("full_ready", {7'b0, mv_ready}, 8'h00);
    chk("full_busy", {7'b0, busy}, 8'h01);
    read_byte(1'b1);
    read_byte(1'b0);
    chk("ready_after_pop", {7'b0, mv_ready}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      read_byte(1'b1);
      read_byte(1'b0);
    end
    idle_chk("full");

    flush_t();
    push_mv(6'd1, 6'd2, 2'b01);
    push_mv(6'd3, 6'd4, 2'b10);
    read_byte(1'b1);
    @(negedge clk);
    obs_q.push_back(out_byte);
    rd_pin = 1'b1;
    repeat (SYNC) @(posedge clk);
    @(negedge clk);
    mv_valid = 1'b1;
    mv_from = 6'd5;
    mv_to = 6'd63;
    mv_flags = 2'b11;
    expect_move(6'd5, 6'd63, 2'b11);
    @(negedge clk);
    mv_valid = 1'b0;
    repeat (SYNC) @(posedge clk);
    @(negedge clk);
    rd_pin = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    push_mv(6'd7, 6'd8, 2'b00);
    @(negedge clk);
    chk("simul_ready", {7'b0, mv_ready}, 8'h01);
    pulse_done(4);
    for (int k = 0; k < 6; k++) read_byte(k % 2 == 0);
    read_end();
    idle_chk("simul");

    flush_t();
    push_mv(6'd9, 6'd10, 2'b00);
    push_mv(6'd11, 6'd12, 2'b01);
    push_mv(6'd13, 6'd14, 2'b10);
    pulse_done(3);
    read_byte(1'b1);
    @(negedge clk);
    flush = 1'b1;
    mv_valid = 1'b1;
    mv_from = 6'd20;
    @(negedge clk);
    flush = 1'b0;
    mv_valid = 1'b0;
    chk("flush_out", out_byte, 8'h00);
    chk("flush_busy", {7'b0, busy}, 8'h00);
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("flush_out2", out_byte, 8'h00);
    chk("flush_busy2", {7'b0, busy}, 8'h00);

    push_mv(6'd30, 6'd31, 2'b00);
    push_mv(6'd32, 6'd33, 2'b01);
    read_byte(1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", out_byte, 8'h00);
    chk("midrst_busy", {7'b0, busy}, 8'h00);
    chk("midrst_ready", {7'b0, mv_ready}, 8'h01);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 6; r++) begin
      flush_t();
      n = $urandom_range(1, 10);
      fork
        drv(n);
        rdr(n);
      join
      idle_chk("rand");
    end

    repeat (2) @(negedge clk);
    chk("exp_left", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
